// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for fifo_stream_reader: boolean constants, stream word
// type and the skid-depth helper used to size the internal queue.
package fifo_stream_reader_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic ONE   = 1'b1;
  localparam logic ZERO  = 1'b0;

  // Default word width; must match the upstream FIFO.
  localparam int WORD_WIDTH = 32;
  typedef logic [WORD_WIDTH-1:0] word_t;

  // Queue depth from its log2 size.
  function automatic int skid_depth(input int depth_bits);
    return 1 << depth_bits;
  endfunction

  localparam int DEFAULT_SKID_DEPTH_IN_BITS = 2;
  localparam int DEFAULT_SKID_DEPTH         = skid_depth(DEFAULT_SKID_DEPTH_IN_BITS);

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundle of the FIFO read-port signals and the outgoing valid/ready stream.
// master = the reader block, slave = the FIFO/sink environment.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 32
) ();

  logic             fifo_req;
  logic             fifo_empty;
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output fifo_req,
    input  fifo_empty,
    input  fifo_valid,
    input  fifo_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output busy
  );

  modport slave (
    input  fifo_req,
    output fifo_empty,
    output fifo_valid,
    output fifo_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  busy
  );

endinterface

// File: rtl/fifo_stream_reader_skid.sv
// Register-based skid queue for fifo_stream_reader. Pointers carry one extra
// wrap bit so a full queue is distinguishable from an empty one.
module fifo_stream_reader_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH_BITS = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    data_i,
  input  logic                pop_i,
  output logic [WIDTH-1:0]    head_o,
  output logic [DEPTH_BITS:0] count_o,
  output logic [DEPTH_BITS:0] count_next_o,
  output logic                empty_o
);

  localparam int DEPTH = skid_depth(DEPTH_BITS);
  localparam int PTR_W = DEPTH_BITS + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;

  // Pointer advance and occupancy, including the count after this edge.
  always_comb begin
    wr_ptr_d     = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_o      = wr_ptr_q - rd_ptr_q;
    count_next_o = wr_ptr_d - rd_ptr_d;
    empty_o      = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    head_o       = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];
  end

  // Read/write pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage: each returning FIFO word lands at the write pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= data_i;
    end
  end

  // The credit scheme must never let a word arrive into a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push_i && full))
    else $error("fifo_stream_reader_skid: push while full");

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a request/latency-N FIFO read port into a
// valid/ready stream with full back-pressure. Credit counter for in-flight
// requests, skid queue for returning words, registered output stage.
// Optional statistics counters: define FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH              = WORD_WIDTH,
  parameter int READ_LATENCY       = 2,
  parameter int SKID_DEPTH_IN_BITS = DEFAULT_SKID_DEPTH_IN_BITS,
  parameter int STAT_WIDTH         = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  fifo_stream_reader_if.master bus
`ifdef FIFO_STREAM_READER_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_words,
  output logic [STAT_WIDTH-1:0] stat_stall
`endif
);

  localparam int DEPTH = skid_depth(SKID_DEPTH_IN_BITS);
  localparam int CNT_W = SKID_DEPTH_IN_BITS + 1;
  localparam int SUM_W = SKID_DEPTH_IN_BITS + 2;

  // Reject parameter sets the credit scheme cannot support.
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("fifo_stream_reader: READ_LATENCY must be in 1..4");
  end
  if (SKID_DEPTH_IN_BITS < 1) begin : g_bad_depth
    $error("fifo_stream_reader: SKID_DEPTH_IN_BITS must be at least 1");
  end
  if (STAT_WIDTH < 1) begin : g_bad_stat
    $error("fifo_stream_reader: STAT_WIDTH must be at least 1");
  end

  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             busy_q, busy_d;

  logic [CNT_W-1:0] skid_count, skid_count_next;
  logic             skid_empty;
  logic [WIDTH-1:0] skid_head;

  logic             fifo_req;
  logic             accept;
  logic             out_hold;
  logic             load_en;
  logic             push;
  logic             pop;
  logic             bypass;
  logic [SUM_W-1:0] credit_sum;

  // Credits cover words still in flight, words queued and a stalled output word.
  always_comb begin
    out_hold   = out_valid_q & ~bus.out_ready;
    credit_sum = SUM_W'(inflight_q) + SUM_W'(skid_count) + SUM_W'(out_hold);
    fifo_req   = ~bus.fifo_empty & (credit_sum < SUM_W'(DEPTH + 1)) & reset_n;
    accept     = fifo_req & ~bus.fifo_empty;
  end

  // Output register refills from the queue head, or straight from the FIFO
  // when the queue is empty, so no cycle is lost on an idle stream.
  always_comb begin
    load_en = ~out_valid_q | bus.out_ready;
    pop     = load_en & ~skid_empty;
    bypass  = load_en & skid_empty & bus.fifo_valid;
    push    = bus.fifo_valid & ~bypass;
  end

  // Next-state for credit counter, output stage and busy flag.
  always_comb begin
    inflight_d  = inflight_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case ({accept, bus.fifo_valid})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (load_en) begin
      if (!skid_empty) begin
        out_valid_d = TRUE;
        out_data_d  = skid_head;
      end else if (bus.fifo_valid) begin
        out_valid_d = TRUE;
        out_data_d  = bus.fifo_data;
      end else begin
        out_valid_d = FALSE;
      end
    end

    busy_d = (inflight_d != '0) | (skid_count_next != '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q  <= '0;
      out_valid_q <= ZERO;
      out_data_q  <= '0;
      busy_q      <= ZERO;
    end else begin
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  fifo_stream_reader_skid #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (SKID_DEPTH_IN_BITS)
  ) u_skid (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push),
    .data_i       (bus.fifo_data),
    .pop_i        (pop),
    .head_o       (skid_head),
    .count_o      (skid_count),
    .count_next_o (skid_count_next),
    .empty_o      (skid_empty)
  );

  assign bus.fifo_req  = fifo_req;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [STAT_WIDTH-1:0] stat_words_q, stat_stall_q;
  logic                  xfer;

  assign xfer = out_valid_q & bus.out_ready;

  // Saturating transfer and stall counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (xfer && (stat_words_q != '1))     stat_words_q <= stat_words_q + STAT_WIDTH'(1);
      if (out_hold && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + STAT_WIDTH'(1);
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader. A latency-2 FIFO read port is emulated with
// queues; the expected stream is the ordered list of words returned but not
// yet transferred. Statistics checks run when FIFO_STREAM_READER_STATS_EN is defined.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int RL    = 2;
  localparam int DB    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(32)) bus ();

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [31:0] stat_words, stat_stall;
`endif

  fifo_stream_reader #(
    .WIDTH              (32),
    .READ_LATENCY       (RL),
    .SKID_DEPTH_IN_BITS (DB),
    .STAT_WIDTH         (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  word_t fifo_q[$];      // words still inside the upstream FIFO
  word_t pend_d[$];      // requested words travelling through the read latency
  int    pend_due[$];    // cycle at which each pending word shows up on fifo_valid
  word_t held_q[$];      // returned, not yet transferred (front = expected out_data)
  word_t sent[$];
  word_t got[$];
  int    inflight_m;
  int    cyc;
  int    checks;
  int    failures;
  int    accepts;
  int    xfers;
  int    first_acc;
  int    first_ov;
  int    first_xfer;
  int    last_xfer;
  logic  ready_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic load(input word_t base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + word_t'(i));
      sent.push_back(base + word_t'(i));
    end
  endtask

  task automatic start_scn();
    got.delete();
    sent.delete();
    xfers      = 0;
    first_xfer = -1;
    last_xfer  = -1;
  endtask

  task automatic clear_model();
    fifo_q.delete();
    pend_d.delete();
    pend_due.delete();
    held_q.delete();
    inflight_m = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step();
    logic  acc, xf, v, exp_req;
    word_t d, w;
    int    held, skid, hold;
    bus.fifo_empty = (fifo_q.size() == 0);
    if (pend_d.size() > 0 && pend_due[0] == cyc) begin
      bus.fifo_valid = 1'b1;
      bus.fifo_data  = pend_d[0];
    end else begin
      bus.fifo_valid = 1'b0;
      bus.fifo_data  = 32'hDEAD_BEEF;
    end
    bus.out_ready = ready_drv;
    #1;
    held    = held_q.size();
    skid    = (held > 0) ? held - 1 : 0;
    hold    = (held > 0 && !ready_drv) ? 1 : 0;
    exp_req = (reset_n === 1'b1) && (fifo_q.size() != 0) && (inflight_m + skid + hold < DEPTH + 1);
    check("fifo_req", {31'd0, bus.fifo_req}, {31'd0, exp_req});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, held > 0});
    if (held > 0) check("out_data", bus.out_data, held_q[0]);
    check("busy", {31'd0, bus.busy}, {31'd0, (inflight_m != 0) || (held > 1)});
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    acc = bus.fifo_req & ~bus.fifo_empty;
    xf  = bus.out_valid & bus.out_ready;
    v   = bus.fifo_valid;
    d   = bus.fifo_data;
    @(posedge clk);
    if (xf && held_q.size() > 0) begin
      w = held_q.pop_front();
      got.push_back(w);
      xfers++;
      if (first_xfer < 0) first_xfer = cyc;
      last_xfer = cyc;
      $display("xfer cyc=%0d data=0x%08h", cyc, w);
    end
    if (v) begin
      held_q.push_back(d);
      void'(pend_d.pop_front());
      void'(pend_due.pop_front());
      inflight_m--;
    end
    if (acc && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      pend_d.push_back(w);
      pend_due.push_back(cyc + RL);
      inflight_m++;
      accepts++;
      if (first_acc < 0) first_acc = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Run until every loaded word is delivered. mode 0: ready=1, 1: toggling,
  // 2: exactly three stall cycles once a word is presented.
  task automatic drain(input int mode);
    int guard  = 0;
    int stalls = 0;
    while (!(fifo_q.size() == 0 && pend_d.size() == 0 && held_q.size() == 0)) begin
      if (guard >= 400) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout actual=%0d cycles required=<400 held=%0d", guard, held_q.size());
        break;
      end
      case (mode)
        1:       ready_drv = ~ready_drv;
        2: begin
          if (bus.out_valid && stalls < 3) begin
            ready_drv = 1'b0;
            stalls++;
          end else begin
            ready_drv = 1'b1;
          end
        end
        default: ready_drv = 1'b1;
      endcase
      step();
      guard++;
    end
    ready_drv = 1'b1;
    step();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic verify_order(input string name);
    check({name, "_count"}, got.size(), sent.size());
    for (int i = 0; i < got.size() && i < sent.size(); i++) check({name, "_word"}, got[i], sent[i]);
  endtask

  initial begin
    int release_cyc, acc0;
    checks = 0; failures = 0; accepts = 0; cyc = 0;
    first_acc = -1; first_ov = -1;
    clear_model();
    ready_drv      = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_valid = 1'b0;
    bus.fifo_data  = '0;
    bus.out_ready  = 1'b1;

    // Reset held with a preloaded FIFO.
    start_scn();
    load(32'hA0, 5);
    @(negedge clk);
    repeat (3) step();
    check("rst_req", {31'd0, bus.fifo_req}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    check("rst_stat_words", stat_words, 32'd0);
    check("rst_stat_stall", stat_stall, 32'd0);
`endif
    reset_n     = 1'b1;
    release_cyc = cyc;
    first_acc   = -1;
    first_ov    = -1;
    drain(0);
    check("rel_first_req", first_acc, release_cyc);
    check("rel_first_valid", first_ov, first_acc + 3);
    check("rel_first_word", got.size() > 0 ? got[0] : 32'hFFFF_FFFF, 32'hA0);
    verify_order("rel");

    // Streaming with a sink that is always ready.
    start_scn();
    load(32'h10, 16);
    drain(0);
    check("stream_xfers", xfers, 32'd16);
    check("stream_span", last_xfer - first_xfer, 32'd15);
    check("stream_first", got.size() > 0 ? got[0] : 32'hFFFF_FFFF, 32'h10);
    check("stream_last", got.size() > 0 ? got[got.size()-1] : 32'hFFFF_FFFF, 32'h1F);
    verify_order("stream");

    // Back-pressure: sink stalled for 20 cycles.
    start_scn();
    load(32'h20, 8);
    acc0      = accepts;
    ready_drv = 1'b0;
    repeat (20) step();
    check("bp_accepts", accepts - acc0, 32'd5);
    check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    check("bp_hold_data", bus.out_data, 32'h20);
    check("bp_busy", {31'd0, bus.busy}, 32'd1);
    drain(0);
    check("bp_xfers", xfers, 32'd8);
    verify_order("bp");

    // Bubbly sink.
    start_scn();
    load(32'h30, 10);
    drain(1);
    check("bubble_xfers", xfers, 32'd10);
    verify_order("bubble");

    // FIFO runs empty with two requests in flight.
    start_scn();
    load(32'h40, 2);
    acc0 = accepts;
    step();
    step();
    bus.fifo_empty = (fifo_q.size() == 0);
    #1;
    check("race_accepts", accepts - acc0, 32'd2);
    check("race_req_off", {31'd0, bus.fifo_req}, 32'd0);
    check("race_busy", {31'd0, bus.busy}, 32'd1);
    drain(0);
    check("race_xfers", xfers, 32'd2);
    verify_order("race");

`ifdef FIFO_STREAM_READER_STATS_EN
    // Statistics: fresh reset, 6 transfers with 3 stall cycles.
    reset_n = 1'b0;
    clear_model();
    #1;
    check("st_rst_words", stat_words, 32'd0);
    check("st_rst_stall", stat_stall, 32'd0);
    step();
    reset_n = 1'b1;
    start_scn();
    load(32'h50, 6);
    drain(2);
    check("st_words", stat_words, 32'd6);
    check("st_stall", stat_stall, 32'd3);
    verify_order("st");
`endif

    // Asynchronous reset while words are held.
    start_scn();
    load(32'h60, 4);
    ready_drv = 1'b0;
    repeat (6) step();
    check("mid_pre_valid", {31'd0, bus.out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_req", {31'd0, bus.fifo_req}, 32'd0);
    check("mid_rst_data", bus.out_data, 32'd0);
`ifdef FIFO_STREAM_READER_STATS_EN
    check("mid_rst_words", stat_words, 32'd0);
    check("mid_rst_stall", stat_stall, 32'd0);
`endif
    clear_model();
    ready_drv = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Downstream consumer of the team's request/latency-2 FIFO read port.
- Converts the FIFO's req_r / valid_r / data_r / empty interface into a valid/ready stream, with full back-pressure.
- Tracks in-flight read requests with a credit counter and lands returning data in a small internal skid queue, so no word is ever dropped or duplicated.
- Sits between any FIFO instance and a stream sink (e.g. core inbox, DMA writer).

Parameters:
- WIDTH, 32, data word width; must match the upstream FIFO.
- READ_LATENCY, 2, cycles from an accepted request (fifo_req=1 and fifo_empty=0) to fifo_valid; legal range 1..4.
- SKID_DEPTH_IN_BITS, 2, log2 of skid queue depth; depth must be ≥ READ_LATENCY+1 for full throughput.
- STAT_WIDTH, 32, counter width used only when the optional feature is enabled.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- fifo_req, out, 1, read request to FIFO (drives FIFO req_r); combinational.
- fifo_empty, in, 1, FIFO empty flag.
- fifo_valid, in, 1, FIFO valid_r.
- fifo_data, in, WIDTH, FIFO data_r.
- out_valid, out, 1, stream word available; registered.
- out_ready, in, 1, sink accepts word.
- out_data, out, WIDTH, stream word; registered.
- busy, out, 1, inflight≠0 or skid queue non-empty; registered.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low; all state clears on assertion.
- Reset values: out_valid=0, out_data=0, busy=0, inflight=0, skid pointers=0.
- Accepted request: accept = fifo_req & ~fifo_empty. The FIFO ignores requests while empty, so only accepted requests consume credit.
- fifo_req: fifo_req = ~fifo_empty & (inflight + skid_count + out_valid_hold < SKID_DEPTH + 1) & reset_n.
  - Credits cover every word that may still arrive, plus those held.
  - out_valid_hold is 1 when out_valid=1 and out_ready=0.
- Credit counter: inflight (width SKID_DEPTH_IN_BITS+1) counts accepted requests whose data has not yet returned.
  - Increments on accept; decrements on fifo_valid.
  - Both in the same cycle: unchanged.
- Skid queue: register-based, depth 1<<SKID_DEPTH_IN_BITS, separate read/write pointers with one extra wrap bit, so full is distinguishable from empty.
  - Every fifo_valid=1 writes fifo_data.
  - Overflow is impossible by credit rule. The verification assertion is: fifo_valid while the queue is full is an error.
- Output stage: a single register pair (out_valid, out_data).
  - Loads from the queue head when out_valid=0, or when out_valid=1 & out_ready=1, and the queue is non-empty (or a bypass word arrives the same cycle with the queue empty).
  - Word order is strictly preserved.
- Latency: empty stream, FIFO non-empty → fifo_req cycle t → fifo_valid at t+READ_LATENCY → out_valid at t+READ_LATENCY+1.
- Throughput: with out_ready held 1, one word per cycle sustained.
- Handshake: out_data and out_valid stay stable while out_valid=1 & out_ready=0. A transfer occurs on out_valid & out_ready at a rising edge.
- Simultaneous events: enqueue, dequeue and output load in the same cycle are all legal, and the count updates by net change.
- fifo_empty rising while requests are in flight: in-flight words still return and are delivered; no new requests are issued.
- reset_n asserted mid-operation: all state is dropped immediately. Words returning after reset release are not tracked; the integrator must reset the FIFO together with this block.

Optional Feature:
- Macro: FIFO_STREAM_READER_STATS_EN.
- Defined:
  - Adds outputs stat_words (STAT_WIDTH) and stat_stall (STAT_WIDTH), both reset to 0 and saturating at all-ones.
  - stat_words increments on each stream transfer.
  - stat_stall increments each cycle with out_valid=1 & out_ready=0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - TRUE/FALSE/ONE/ZERO constants.
  - A localparam helper for skid depth.
  - The stream word typedef sized by WIDTH.
- One natural sub-module: fifo_stream_reader_skid, the register queue with push/pop/count. The top holds the credit logic and output register.

Test Plan:
- Reset: hold reset_n=0 with FIFO preloaded with 5 words → fifo_req=0, out_valid=0, busy=0; release → first fifo_req next cycle, out_valid=1 three cycles after the first accepted request.
- Streaming: FIFO holds 0x10..0x1F, out_ready=1 constantly → 16 transfers on consecutive cycles, data 0x10..0x1F in order, busy falls after the last transfer.
- Back-pressure: 8 words queued, out_ready=0 for 20 cycles → accepted requests stop at 5 total (4 queued + 1 in output), out_data stable at first word; then out_ready=1 → remaining words delivered in order, none lost.
- Bubbly sink: out_ready toggles 1,0,1,0 over 10 words → exactly 10 transfers, order preserved, no duplicates.
- Empty race: FIFO goes empty with 2 requests in flight → both words delivered, then fifo_req=0, busy=0 after the last transfer.
- With FIFO_STREAM_READER_STATS_EN: 6 transfers with 3 stall cycles → stat_words=6, stat_stall=3; after reset both are 0.
